// File: rtl/core_credit_scheduler.sv
// core_credit_scheduler: boot-time core reset sequencer plus credit-based core selection for RX ports.
//   clk, rst_n                 clock, synchronous active-low reset
//   port_req / port_gnt        per-port level request, registered one-hot single-cycle grant
//   port_gnt_core              core assigned to the granted port (valid with port_gnt)
//   core_enable                cores eligible for selection and for the init credit wait
//   reinit                     pulse restarting the core reset sequence
//   ctrl_s_axis_*              credit returns from cores (tdata top nibble 4'h1 = one slot freed)
//   ctrl_m_axis_*              reset commands to cores, tdest = core index
//   sched_state, init_done     0=RST_CORES, 1=WAIT_CRED, 2=RUN; init_done high in RUN
//   credit_overflow            sticky: credit returned to a full counter
// Build option: define STRICT_PRIO_PORT0_EN for fixed port priority (port 0 highest) instead of round-robin.
module core_credit_scheduler #(
    parameter int CORE_COUNT     = 16,
    parameter int PORT_COUNT     = 2,
    parameter int SLOT_COUNT     = 8,
    parameter int DATA_WIDTH     = 64,
    parameter int CORE_CNT_WIDTH = $clog2(CORE_COUNT),
    parameter int CRED_WIDTH     = $clog2(SLOT_COUNT) + 1,
    parameter int INIT_TIMEOUT   = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PORT_COUNT-1:0]     port_req,
    output logic [PORT_COUNT-1:0]     port_gnt,
    output logic [CORE_CNT_WIDTH-1:0] port_gnt_core,
    input  logic [CORE_COUNT-1:0]     core_enable,
    input  logic                      reinit,
    input  logic [DATA_WIDTH-1:0]     ctrl_s_axis_tdata,
    input  logic [CORE_CNT_WIDTH-1:0] ctrl_s_axis_tuser,
    input  logic                      ctrl_s_axis_tvalid,
    output logic                      ctrl_s_axis_tready,
    output logic [DATA_WIDTH-1:0]     ctrl_m_axis_tdata,
    output logic [CORE_CNT_WIDTH-1:0] ctrl_m_axis_tdest,
    output logic                      ctrl_m_axis_tvalid,
    input  logic                      ctrl_m_axis_tready,
    output logic                      ctrl_m_axis_tlast,
    output logic [1:0]                sched_state,
    output logic                      init_done,
    output logic                      credit_overflow
);

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam int TW = $clog2(INIT_TIMEOUT + 1);
    localparam int PW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
    localparam logic [CRED_WIDTH-1:0] FULL = CRED_WIDTH'(SLOT_COUNT);

    logic [1:0]                state_q, state_d;
    logic [CRED_WIDTH-1:0]     credit_q [CORE_COUNT];
    logic [CRED_WIDTH-1:0]     credit_d [CORE_COUNT];
    logic [CORE_CNT_WIDTH-1:0] core_cnt_q, core_cnt_d;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic [PORT_COUNT-1:0]     gnt_q, gnt_d;
    logic [CORE_CNT_WIDTH-1:0] gnt_core_q, gnt_core_d;
    logic                      ovf_q, ovf_d;

    logic                      m_fire, msg_ok, all_full, grant, port_found;
    logic [PORT_COUNT-1:0]     elig;
    logic [PW-1:0]             port_sel;
    logic [CORE_CNT_WIDTH-1:0] core_sel;
    logic [CRED_WIDTH-1:0]     core_best;
    logic [CORE_COUNT-1:0]     inc, dec;
    logic                      unused_tdata;

    assign m_fire = ctrl_m_axis_tvalid & ctrl_m_axis_tready;
    assign msg_ok = ctrl_s_axis_tvalid & ctrl_s_axis_tready
                  & (ctrl_s_axis_tdata[DATA_WIDTH-1 -: 4] == 4'h1)
                  & (int'(ctrl_s_axis_tuser) < CORE_COUNT);
    assign unused_tdata = ^ctrl_s_axis_tdata[DATA_WIDTH-5:0];

    // The port granted last cycle still holds its request while it sees the grant.
    assign elig = port_req & ~gnt_q;

`ifdef STRICT_PRIO_PORT0_EN
    always_comb begin
        port_found = 1'b0;
        port_sel   = '0;
        for (int i = PORT_COUNT - 1; i >= 0; i--) begin
            if (elig[i]) begin
                port_found = 1'b1;
                port_sel   = PW'(i);
            end
        end
    end
`else
    // rr_q holds the port searched first, i.e. the one after the last grant.
    logic [PW-1:0]           rr_q, rr_d;
    logic [2*PORT_COUNT-1:0] elig_rot;
    int                      rot;

    assign elig_rot = {elig, elig} >> rr_q;

    always_comb begin
        port_found = 1'b0;
        port_sel   = '0;
        rot        = 0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (!port_found && elig_rot[i]) begin
                port_found = 1'b1;
                rot        = int'(rr_q) + i;
                port_sel   = PW'(rot >= PORT_COUNT ? rot - PORT_COUNT : rot);
            end
        end
        rr_d = rr_q;
        if (grant)
            rr_d = (port_sel == PW'(PORT_COUNT - 1)) ? '0 : port_sel + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rr_q <= '0;
        else
            rr_q <= rr_d;
    end
`endif

    // Strict '>' keeps the lowest index on ties; a zero best means nothing to grant.
    always_comb begin
        core_sel  = '0;
        core_best = '0;
        for (int c = 0; c < CORE_COUNT; c++) begin
            if (core_enable[c] && credit_q[c] > core_best) begin
                core_best = credit_q[c];
                core_sel  = CORE_CNT_WIDTH'(c);
            end
        end
    end

    assign grant      = (state_q == ST_RUN) && !reinit && port_found && (core_best != '0);
    assign gnt_d      = grant ? ({{(PORT_COUNT-1){1'b0}}, 1'b1} << port_sel) : '0;
    assign gnt_core_d = grant ? core_sel : '0;

    always_comb begin
        ovf_d    = ovf_q;
        all_full = 1'b1;
        for (int c = 0; c < CORE_COUNT; c++) begin
            inc[c]      = msg_ok && (ctrl_s_axis_tuser == CORE_CNT_WIDTH'(c));
            dec[c]      = grant && (core_sel == CORE_CNT_WIDTH'(c));
            credit_d[c] = credit_q[c];
            if (reinit)
                credit_d[c] = '0;
            else if (inc[c] && !dec[c]) begin
                if (credit_q[c] == FULL)
                    ovf_d = 1'b1;
                else
                    credit_d[c] = credit_q[c] + 1'b1;
            end else if (dec[c] && !inc[c])
                credit_d[c] = credit_q[c] - 1'b1;
            // Judged on next-cycle credits so RUN follows the completing return directly.
            if (core_enable[c] && credit_d[c] != FULL)
                all_full = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        core_cnt_d = core_cnt_q;
        tmo_d      = tmo_q;
        if (reinit) begin
            state_d    = ST_RST;
            core_cnt_d = '0;
            tmo_d      = '0;
        end else if (state_q == ST_RST) begin
            if (m_fire) begin
                core_cnt_d = (core_cnt_q == CORE_CNT_WIDTH'(CORE_COUNT - 1)) ? '0 : core_cnt_q + 1'b1;
                state_d    = (core_cnt_q == CORE_CNT_WIDTH'(CORE_COUNT - 1)) ? ST_WAIT : ST_RST;
            end
        end else if (state_q == ST_WAIT) begin
            tmo_d = tmo_q + 1'b1;
            if (all_full || tmo_q == TW'(INIT_TIMEOUT - 1))
                state_d = ST_RUN;
        end else if (state_q != ST_RUN)
            state_d = ST_RST;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RST;
            credit_q   <= '{default: '0};
            core_cnt_q <= '0;
            tmo_q      <= '0;
            gnt_q      <= '0;
            gnt_core_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            core_cnt_q <= core_cnt_d;
            tmo_q      <= tmo_d;
            gnt_q      <= gnt_d;
            gnt_core_q <= gnt_core_d;
            ovf_q      <= ovf_d;
        end
    end

    assign port_gnt           = gnt_q;
    assign port_gnt_core      = gnt_core_q;
    assign ctrl_s_axis_tready = (state_q != ST_RST);
    assign ctrl_m_axis_tvalid = (state_q == ST_RST);
    assign ctrl_m_axis_tdata  = DATA_WIDTH'(64'hFFFF_FFFF_FFFF_FFFE);
    assign ctrl_m_axis_tdest  = core_cnt_q;
    assign ctrl_m_axis_tlast  = 1'b1;
    assign sched_state        = state_q;
    assign init_done          = (state_q == ST_RUN);
    assign credit_overflow    = ovf_q;

endmodule

// File: tb/tb_core_credit_scheduler.sv
// tb_core_credit_scheduler: scoreboard bench for core_credit_scheduler (reset beats, credit init, grants, overflow, reinit).
module tb_core_credit_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  port_req;
    logic [1:0]  port_gnt;
    logic [3:0]  port_gnt_core;
    logic [15:0] core_enable;
    logic        reinit;
    logic [63:0] s_tdata;
    logic [3:0]  s_tuser;
    logic        s_tvalid, s_tready;
    logic [63:0] m_tdata;
    logic [3:0]  m_tdest;
    logic        m_tvalid, m_tready, m_tlast;
    logic [1:0]  sched_state;
    logic        init_done, credit_overflow;

    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    logic [3:0]  exp_beat [$];
    logic [5:0]  exp_gnt [$];
    logic [3:0]  eb;
    logic [5:0]  eg;

    always #5 clk = ~clk;

    core_credit_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .port_req(port_req), .port_gnt(port_gnt), .port_gnt_core(port_gnt_core),
        .core_enable(core_enable), .reinit(reinit),
        .ctrl_s_axis_tdata(s_tdata), .ctrl_s_axis_tuser(s_tuser),
        .ctrl_s_axis_tvalid(s_tvalid), .ctrl_s_axis_tready(s_tready),
        .ctrl_m_axis_tdata(m_tdata), .ctrl_m_axis_tdest(m_tdest),
        .ctrl_m_axis_tvalid(m_tvalid), .ctrl_m_axis_tready(m_tready),
        .ctrl_m_axis_tlast(m_tlast),
        .sched_state(sched_state), .init_done(init_done), .credit_overflow(credit_overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every presented beat or grant must match the head of its queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_tvalid && m_tready) begin
                if (exp_beat.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat_unexpected: tdest %0d presented, expected no beat", m_tdest);
                end else begin
                    eb = exp_beat.pop_front();
                    chk("beat_tdest", 64'(m_tdest), 64'(eb));
                    chk("beat_tdata", m_tdata, 64'hFFFF_FFFF_FFFF_FFFE);
                    chk("beat_tlast", 64'(m_tlast), 64'd1);
                end
            end
            if (port_gnt != 2'b00) begin
                if (exp_gnt.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL gnt_unexpected: port_gnt %0b core %0d, expected no grant", port_gnt, port_gnt_core);
                end else begin
                    eg = exp_gnt.pop_front();
                    chk("gnt_port", 64'(port_gnt), 64'(eg[5:4]));
                    chk("gnt_core", 64'(port_gnt_core), 64'(eg[3:0]));
                end
            end
        end
    end

    task automatic push_beats();
        for (int i = 0; i < 16; i++) exp_beat.push_back(4'(i));
    endtask

    // Called in the first RST_CORES cycle with the beat counter at 0.
    task automatic reset_beats(input string tag);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk({tag, "_state_pre"}, 64'(sched_state), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_state_wait"}, 64'(sched_state), 64'd1);
        chk({tag, "_beats_left"}, 64'(exp_beat.size()), 64'd0);
    endtask

    task automatic drain_gnt(input string tag);
        int n = 0;
        while (exp_gnt.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drained"}, 64'(exp_gnt.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; port_req = '0; core_enable = '1; reinit = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0; m_tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 64'(sched_state), 64'd0);
        chk("rst_gnt", 64'(port_gnt), 64'd0);
        chk("rst_gnt_core", 64'(port_gnt_core), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_ovf", 64'(credit_overflow), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd1);
        chk("rst_m_tdest", 64'(m_tdest), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);

        // Boot: 16 reset beats, then WAIT_CRED.
        push_beats();
        @(posedge clk); #1;
        rst_n = 1'b1; m_tready = 1'b1; mon_en = 1'b1;
        reset_beats("boot");

        // One ignored message, then 8 credits per core; RUN the cycle after the last one.
        @(posedge clk); #1;
        s_tvalid = 1'b1; s_tdata = {4'h2, 60'h0}; s_tuser = 4'd0;
        @(posedge clk); #1;
        for (int i = 0; i < 128; i++) begin
            s_tdata = {4'h1, 60'h0};
            s_tuser = 4'(i);
            if (i == 127) begin
                @(negedge clk);
                chk("cred_not_yet", 64'(sched_state), 64'd1);
            end
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        @(negedge clk);
        chk("cred_run", 64'(sched_state), 64'd2);
        chk("cred_init_done", 64'(init_done), 64'd1);
        chk("cred_no_ovf", 64'(credit_overflow), 64'd0);
        chk("run_s_tready", 64'(s_tready), 64'd1);
        chk("run_m_tvalid", 64'(m_tvalid), 64'd0);

        // Only cores 3 and 5 enabled: 16 alternating grants, then none.
        @(posedge clk); #1;
        core_enable = 16'h0028; port_req = 2'b11;
        for (int k = 0; k < 16; k++)
            exp_gnt.push_back({(k % 2) ? 2'b10 : 2'b01, (k % 2) ? 4'd5 : 4'd3});
        drain_gnt("rr");
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        port_req = 2'b00;

        // Return to full core 2 sets the sticky overflow.
        s_tvalid = 1'b1; s_tdata = {4'h1, 60'h0}; s_tuser = 4'd2;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        chk("ovf_set", 64'(credit_overflow), 64'd1);

        // Cores 4 and 6 at 8: grant+return on 4 keeps it at 8, so 4 wins the tie again.
        @(posedge clk); #1;
        core_enable = 16'h0050; port_req = 2'b01;
        s_tvalid = 1'b1; s_tuser = 4'd4;
        exp_gnt.push_back({2'b01, 4'd4});
        @(posedge clk); #1;
        s_tvalid = 1'b0; port_req = 2'b10;
        exp_gnt.push_back({2'b10, 4'd4});
        @(posedge clk); #1;
        port_req = 2'b01;
        exp_gnt.push_back({2'b01, 4'd6});
        @(posedge clk); #1;
        port_req = 2'b00;
        drain_gnt("net");

        // reinit together with a grantable request: no grant, beats restart at core 0.
        @(posedge clk); #1;
        core_enable = 16'h0040; port_req = 2'b01; reinit = 1'b1;
        @(posedge clk); #1;
        port_req = 2'b00; reinit = 1'b0; core_enable = '1;
        push_beats();
        @(negedge clk);
        chk("reinit_gnt", 64'(port_gnt), 64'd0);
        chk("reinit_state", 64'(sched_state), 64'd0);
        chk("reinit_init_done", 64'(init_done), 64'd0);
        chk("reinit_ovf_kept", 64'(credit_overflow), 64'd1);
        chk("reinit_m_tvalid", 64'(m_tvalid), 64'd1);
        chk("reinit_m_tdest", 64'(m_tdest), 64'd0);
        reset_beats("reinit");

        // No credits: RUN after exactly INIT_TIMEOUT cycles in WAIT_CRED.
        repeat (1023) @(posedge clk);
        @(negedge clk);
        chk("tmo_still_wait", 64'(sched_state), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("tmo_run", 64'(sched_state), 64'd2);
        chk("tmo_init_done", 64'(init_done), 64'd1);

        // All cores disabled: WAIT_CRED lasts a single cycle.
        @(posedge clk); #1;
        reinit = 1'b1; core_enable = '0;
        push_beats();
        @(posedge clk); #1;
        reinit = 1'b0;
        reset_beats("dis");
        @(negedge clk);
        chk("dis_run", 64'(sched_state), 64'd2);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
